// File: rtl/audio_pkg.sv
// Shared constants, state type and helpers for the microphone level meter.
package audio_pkg;

  localparam int MID_DEFAULT    = 2048;
  localparam int STEP_DEFAULT   = 227;
  localparam int WINDOW_DEFAULT = 4000;

  localparam int LEVEL_MAX = 9;
  localparam int LEVEL_W   = 4;
  localparam int SAMPLE_W  = 12;
  localparam int LED_W     = LEVEL_MAX;
  localparam int CNT_W     = 16;

  typedef enum logic {
    ACCUM,
    EVAL
  } meter_state_e;

  // Thermometer bar: bit i lit iff i < lvl.
  function automatic logic [LED_W-1:0] level_to_bar(input logic [LEVEL_W-1:0] lvl);
    logic [LED_W-1:0] bar;
    for (int i = 0; i < LED_W; i++) begin
      bar[i] = (i < int'(lvl));
    end
    return bar;
  endfunction

endpackage

// File: rtl/mic_level_meter_if.sv
// Sample stream in, level/bar display out.
interface mic_level_meter_if;
  import audio_pkg::*;

  logic                sample_clk;
  logic [SAMPLE_W-1:0] sample;
  logic [LEVEL_W-1:0]  level;
  logic [LED_W-1:0]    led;
  logic                level_valid;

  modport master (
    output sample_clk, sample,
    input  level, led, level_valid
  );

  modport slave (
    input  sample_clk, sample,
    output level, led, level_valid
  );

endinterface

// File: rtl/edge_sync.sv
// Two-flop synchroniser with a one-clock rising-edge pulse; usable for any slow strobe.
module edge_sync (
  input  logic clock,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q, sync_q, sync_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      sync_d <= sync_q;
    end
  end

  assign rise = sync_q & ~sync_d;

endmodule

// File: rtl/mic_level_meter.sv
// Peak-hold volume meter: windowed peak amplitude quantised to 0..9 with one-step decay.
// state | meaning
// ACCUM | collecting samples into the running window peak
// EVAL  | one cycle: quantise closing peak, update level/led, pulse level_valid
module mic_level_meter
  import audio_pkg::*;
#(
  parameter int MID    = MID_DEFAULT,
  parameter int STEP   = STEP_DEFAULT,
  parameter int WINDOW = WINDOW_DEFAULT
) (
  input logic           clock,
  input logic           rst_n,
  mic_level_meter_if.slave bus
);

  localparam logic [SAMPLE_W-1:0] MID_V = SAMPLE_W'(MID);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(WINDOW - 1);

  meter_state_e state, state_next;

  logic                tick;
  logic                close;
  logic                eval;
  logic [SAMPLE_W-1:0] amp;
  logic [SAMPLE_W-1:0] peak;
  logic [SAMPLE_W-1:0] peak_upd;
  logic [SAMPLE_W-1:0] closing_peak;
  logic [CNT_W-1:0]    win_cnt;
  logic [LEVEL_W-1:0]  new_level;
  logic [LEVEL_W-1:0]  level_next;
  logic [LEVEL_W-1:0]  level_q;
  logic [LED_W-1:0]    led_q;
  logic                valid_q;

  edge_sync u_sample_sync (
    .clock    (clock),
    .rst_n    (rst_n),
    .async_in (bus.sample_clk),
    .rise     (tick)
  );

  always_comb begin
    amp      = (bus.sample >= MID_V) ? (bus.sample - MID_V) : (MID_V - bus.sample);
    peak_upd = (amp > peak) ? amp : peak;
    close    = tick && (win_cnt == LAST);
  end

  // The closing sample is folded into closing_peak while the running peak restarts.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      peak         <= '0;
      win_cnt      <= '0;
      closing_peak <= '0;
    end else if (tick) begin
      if (close) begin
        closing_peak <= peak_upd;
        peak         <= '0;
        win_cnt      <= '0;
      end else begin
        peak    <= peak_upd;
        win_cnt <= win_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    eval       = 1'b0;
    case (state)
      ACCUM: if (close) state_next = EVAL;
      EVAL: begin
        eval       = 1'b1;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    new_level = '0;
    for (int k = 1; k <= LEVEL_MAX; k++) begin
      if (int'(closing_peak) >= k * STEP) new_level = new_level + LEVEL_W'(1);
    end
    level_next = (new_level >= level_q) ? new_level : (level_q - LEVEL_W'(1));
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      led_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= eval;
      if (eval) begin
        level_q <= level_next;
        led_q   <= level_to_bar(level_next);
      end
    end
  end

  assign bus.level       = level_q;
  assign bus.led         = led_q;
  assign bus.level_valid = valid_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Self-checking bench for mic_level_meter: directed windows then random windows vs a behavioural model.
module tb_mic_level_meter;

  localparam int WIN  = 8;
  localparam int MIDV = 2048;
  localparam int STPV = 227;

  logic clock;
  logic rst_n;

  mic_level_meter_if bus ();

  mic_level_meter #(
    .MID    (MIDV),
    .STEP   (STPV),
    .WINDOW (WIN)
  ) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int vcount  = 0;

  int ref_level = 0;
  int win_n     = 0;
  int win_peak  = 0;
  int windows   = 0;

  always @(negedge clock) begin
    if (rst_n && bus.level_valid) vcount++;
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int quantise(input int pk);
    int n = 0;
    for (int k = 1; k <= 9; k++) if (pk >= k * STPV) n++;
    return n;
  endfunction

  task automatic send(input int val);
    int  a;
    int  newl;
    bit  closing;
    a        = (val >= MIDV) ? val - MIDV : MIDV - val;
    win_peak = (a > win_peak) ? a : win_peak;
    win_n++;
    closing  = (win_n == WIN);
    @(posedge clock); #1;
    bus.sample     = 12'(val);
    bus.sample_clk = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
    end
    if (closing) check_val("valid_before_eval", int'(bus.level_valid), 0);
    @(posedge clock); #1;
    if (closing) begin
      newl      = quantise(win_peak);
      ref_level = (newl >= ref_level) ? newl : ref_level - 1;
      windows++;
      win_n     = 0;
      win_peak  = 0;
      check_val("valid_pulse", int'(bus.level_valid), 1);
      check_val("level", int'(bus.level), ref_level);
      check_val("led", int'(bus.led), (1 << ref_level) - 1);
    end
    bus.sample_clk = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check_val("valid_count", vcount, windows);
  endtask

  task automatic spike_window(input int val, input int pos);
    for (int i = 0; i < WIN; i++) send((i == pos) ? val : MIDV);
  endtask

  task automatic reset_pulse_check();
    @(posedge clock); #1;
    rst_n = 1'b0;
    for (int t = 0; t < 3; t++) begin
      bus.sample_clk = 1'b1;
      repeat (2) @(posedge clock);
      bus.sample_clk = 1'b0;
      repeat (2) @(posedge clock);
    end
    #1;
    check_val("rst_level", int'(bus.level), 0);
    check_val("rst_led", int'(bus.led), 0);
    check_val("rst_valid", int'(bus.level_valid), 0);
    @(posedge clock); #1;
    rst_n     = 1'b1;
    ref_level = 0;
    win_n     = 0;
    win_peak  = 0;
    repeat (2) @(posedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.sample_clk = 1'b0;
    bus.sample     = 12'(MIDV);
    reset_pulse_check();

    spike_window(MIDV, -1);
    spike_window(3048, 2);
    spike_window(3048, 7);

    for (int i = 0; i < 3; i++) send(MIDV + 900);
    reset_pulse_check();
    spike_window(MIDV, -1);

    spike_window(MIDV + 681, 4);
    spike_window(MIDV + 680, 1);

    spike_window(0, 5);
    for (int w = 0; w < 3; w++) spike_window(MIDV, -1);

    for (int w = 0; w < 20; w++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < WIN; i++) begin
        int v;
        int k;
        case (mode)
          0: v = MIDV - 50 + $urandom_range(0, 100);
          1: v = $urandom_range(0, 4095);
          default: begin
            k = $urandom_range(1, 9);
            v = ($urandom_range(0, 1) == 1) ? MIDV + k * STPV - $urandom_range(0, 1)
                                             : MIDV - k * STPV + $urandom_range(0, 1);
          end
        endcase
        send(v);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mic_level_meter.md
Name: mic_level_meter

Overview:
- Downstream consumer of the 12-bit microphone sample stream produced by the Audio_Input capture block.
- Strobes in one sample per rising edge of the 20 kHz sampling clock and computes amplitude about mid-scale.
- Tracks peak amplitude over a fixed sample window and quantises it to a 0..9 volume level with one-step-per-window decay.
- Drives the 9-LED bar and the level digit consumed by the seven-segment and audio-input task logic.

Parameters:
- MID, 2048: mic DC baseline subtracted before magnitude.
- STEP, 227: amplitude per level step; level k threshold = k*STEP, k=1..9.
- WINDOW, 4000: samples per measurement window (0.2 s at 20 kHz); legal range 1..65535.

Ports:
- clock  input  1  system clock (100 MHz).
- rst_n  input  1  asynchronous active-low reset.
- sample_clk  input  1  20 kHz sampling clock from the clock divider; treated as a level, edge-detected internally.
- sample  input  12  mic sample; stable between sample_clk rising edges.
- level  output  4  displayed volume level, 0..9.
- led  output  9  thermometer of level: bit i set iff i < level.
- level_valid  output  1  one-clock pulse when level is re-evaluated.

Behaviour:
- Reset (async, rst_n=0): level=0, led=0, level_valid=0, peak=0, window count=0, sync/edge flops=0. All sample_clk edges during reset are ignored. Release is mid-window-safe: the first window starts clean.
- Sync/edge:
  - sample_clk passes through 2 flops; tick = sync1 & ~sync2_delayed.
  - sample is latched on the clock edge where tick=1, i.e. the 3rd clock edge after the sample_clk rise.
- Amplitude:
  - amp = sample>=MID ? sample-MID : MID-sample.
  - 12-bit unsigned, range 0..2048, no saturation.
- Peak: on a latched sample, peak_next = max(peak, amp).
- Window counter:
  - Counts latched samples 0..WINDOW-1.
  - The sample that brings the count to WINDOW-1 closes the window, and that sample IS included in the closing peak.
  - Counter then wraps to 0 and peak clears to 0 in the same cycle.
  - WINDOW=1: every sample closes a window.
- Quantise: new = number of k in 1..9 with closing_peak >= k*STEP (inclusive compare; equality counts).
- Level update, one clock after the closing sample is latched:
  - If new >= level: level <= new.
  - Else: level <= level-1 (decay one step per window, never below new, never below 0).
  - level_valid pulses high that same cycle, every window, even if level is unchanged.
- led is registered, updated in the same cycle as level, always consistent with level. level > 9 is unreachable.
- Overlapping ticks: ticks closer than 3 clocks apart are not supported. The 20 kHz rate is 5000 clocks per period.
- State machine: two phases, ACCUM (collect samples) and EVAL (single-cycle quantise/update, then return to ACCUM). A tick arriving in EVAL is still latched into the fresh window.

Decomposition:
- Shared package audio_pkg: MID, STEP, WINDOW defaults; LEVEL_MAX=9; LEVEL_W=4; SAMPLE_W=12.
- One sub-module, edge_sync (2-flop synchroniser plus rising-edge pulse, async active-low reset). It is reusable for the other clk20k/clk200 strobes in the design.
- Quantiser comparator chain stays inline.

Test Plan (bench overrides WINDOW=8, MID=2048, STEP=227):
- Reset: assert rst_n=0 mid-window while toggling sample_clk -> level=0, led=9'b000000000, level_valid=0. After release, exactly 8 new ticks are needed for the first level_valid.
- Quiet input: 8 samples of 2048 -> one level_valid pulse, level=0, led=0.
- Single spike: seven samples of 2048 plus one of 3048 (amp 1000) -> level=4, led=9'b000001111. Spike placed as the 8th (closing) sample gives the same result.
- Threshold edge: window peak 2048+681 (amp 681) -> level=3. Window peak 2048+680 -> level=2 via decay, if previous was 3.
- Full scale and decay: window containing sample 0 (amp 2048) -> level=9, led=9'h1FF. Then three quiet windows -> level 8, 7, 6, each with one level_valid pulse.
- Timing: rise of sample_clk at edge n -> sample latched at edge n+3. Closing sample -> level/level_valid change at the following edge.
